// File: rtl/bp_mem_tester_pkg.sv
// bp_mem_tester_pkg: cce_mem message layout and tester types.
// Widths follow the default proc config.
package bp_mem_tester_pkg;

    localparam int paddr_width_p = 40;
    localparam int cce_block_width_p = 512;
    localparam int lce_id_width_p = 4;
    localparam int lce_assoc_p = 8;
    localparam int way_id_width_lp = $clog2(lce_assoc_p);
    localparam int block_bytes_lp = cce_block_width_p / 8;
    localparam int block_offset_lp = $clog2(block_bytes_lp);
    localparam int pattern_word_width_gp = 64;
    localparam int pattern_words_lp = cce_block_width_p / pattern_word_width_gp;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'h0,
        e_cce_mem_wr    = 4'h1,
        e_cce_mem_uc_rd = 4'h2,
        e_cce_mem_uc_wr = 4'h3
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'b000,
        e_mem_size_8  = 3'b011,
        e_mem_size_64 = 3'b110
    } bp_mem_msg_size_e;

    typedef struct packed {
        logic [way_id_width_lp-1:0] way_id;
        logic [lce_id_width_p-1:0]  lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_cce_mem_payload_s          payload;
        bp_mem_msg_size_e             size;
        logic [paddr_width_p-1:0]     addr;
        bp_cce_mem_cmd_type_e         msg_type;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef enum logic [2:0] {
        e_idle   = 3'd0,
        e_write  = 3'd1,
        e_wdrain = 3'd2,
        e_read   = 3'd3,
        e_rdrain = 3'd4,
        e_done   = 3'd5
    } bp_mem_tester_state_e;

endpackage

// File: rtl/bp_mem_tester_pattern.sv
// bp_mem_tester_pattern: block pattern for an address.
// Word k = zero-extended (addr + 8k) xor seed.
module bp_mem_tester_pattern
    import bp_mem_tester_pkg::*;
(
    input  logic [paddr_width_p-1:0]     addr,
    input  logic [63:0]                  seed,
    output logic [cce_block_width_p-1:0] data
);

    always_comb begin
        data = '0;
        for (int k = 0; k < pattern_words_lp; k++) begin
            data[k*pattern_word_width_gp +: pattern_word_width_gp] =
                (64'(addr) + 64'(8 * k)) ^ seed;
        end
    end

endmodule

// File: rtl/bp_mem_tester.sv
// bp_mem_tester: writes an address pattern to a block region, reads it back.
// Optional watchdog: define BP_MEM_TESTER_TIMEOUT_EN.
module bp_mem_tester
    import bp_mem_tester_pkg::*;
#(
    parameter logic [paddr_width_p-1:0] base_addr_p = paddr_width_p'(64'h8000_0000),
    parameter int                       num_blocks_p = 64,
    parameter int                       max_outstanding_p = 4,
    parameter logic [63:0]              seed_p = '0,
    parameter int                       timeout_p = 4096
)(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o,
    output logic                            done_o,
    output logic                            pass_o,
    output logic [15:0]                     error_count_o,
    output logic [paddr_width_p-1:0]        first_err_addr_o
);

    localparam int idx_width_lp = (num_blocks_p > 1) ? $clog2(num_blocks_p) : 1;
    localparam int out_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [paddr_width_p-1:0] end_addr_lp =
        base_addr_p + paddr_width_p'(num_blocks_p * block_bytes_lp);

    localparam logic [2:0] s_idle   = 3'(e_idle);
    localparam logic [2:0] s_write  = 3'(e_write);
    localparam logic [2:0] s_wdrain = 3'(e_wdrain);
    localparam logic [2:0] s_read   = 3'(e_read);
    localparam logic [2:0] s_rdrain = 3'(e_rdrain);
    localparam logic [2:0] s_done   = 3'(e_done);

    logic [2:0]                 state_r, state_n;
    logic [idx_width_lp-1:0]    idx_r, idx_n;
    logic [out_width_lp-1:0]    out_r, out_n;
    logic [15:0]                err_cnt_r;
    logic [paddr_width_p-1:0]   first_err_r;

    bp_cce_mem_msg_s              cmd_msg, resp;
    logic [cce_block_width_p-1:0] wr_pattern, rd_pattern;
    logic [paddr_width_p-1:0]     cmd_addr, err_addr;
    logic issuing, checking, rd_phase, last, cmd_fire, dec;
    logic in_region, resp_bad, err_evt, to_evt, err_inc;

    assign issuing  = (state_r == s_write) | (state_r == s_read);
    assign rd_phase = (state_r == s_read) | (state_r == s_rdrain);
    assign checking = issuing | (state_r == s_wdrain) | (state_r == s_rdrain);
    assign last     = idx_r == idx_width_lp'(num_blocks_p - 1);
    assign cmd_fire = issuing & mem_cmd_ready_i
                    & (out_r != out_width_lp'(max_outstanding_p));
    assign cmd_addr = base_addr_p + (paddr_width_p'(idx_r) << block_offset_lp);

    bp_mem_tester_pattern wr_pat (
        .addr (cmd_addr),
        .seed (seed_p),
        .data (wr_pattern)
    );

    always_comb begin
        cmd_msg = '0;
        cmd_msg.msg_type = (state_r == s_write) ? e_cce_mem_wr : e_cce_mem_rd;
        cmd_msg.size = e_mem_size_64;
        cmd_msg.addr = cmd_addr;
        cmd_msg.data = (state_r == s_write) ? wr_pattern : '0;
        mem_cmd_o = '0;
        if (cmd_fire) mem_cmd_o = cmd_msg;
    end

    assign mem_cmd_v_o = cmd_fire;

    assign resp = bp_cce_mem_msg_s'(mem_resp_i);
    assign mem_resp_yumi_o = mem_resp_v_i & checking;

    bp_mem_tester_pattern rd_pat (
        .addr (resp.addr),
        .seed (seed_p),
        .data (rd_pattern)
    );

    // Read data is checked against its own address, so order does not matter
    assign in_region = (resp.addr >= base_addr_p) & (resp.addr < end_addr_lp)
                     & (resp.addr[block_offset_lp-1:0] == '0);
    assign resp_bad = ~in_region
                    | (rd_phase ? ((resp.msg_type != e_cce_mem_rd)
                                   | (resp.data != rd_pattern))
                                : (resp.msg_type != e_cce_mem_wr));
    assign err_evt = mem_resp_yumi_o & resp_bad;
    assign err_inc = err_evt | to_evt;

    logic unused_resp;
    assign unused_resp = ^{resp.payload, resp.size};

    assign dec = mem_resp_yumi_o & (out_r != '0);

    always_comb begin
        out_n = out_r;
        if (cmd_fire & ~dec) out_n = out_r + out_width_lp'(1);
        else if (~cmd_fire & dec) out_n = out_r - out_width_lp'(1);
    end

    always_comb begin
        state_n = state_r;
        idx_n = idx_r;
        case (state_r)
            s_idle: if (start_i) begin
                state_n = s_write;
                idx_n = '0;
            end
            s_write, s_read: if (cmd_fire) begin
                if (last) state_n = (state_r == s_write) ? s_wdrain : s_rdrain;
                else idx_n = idx_r + idx_width_lp'(1);
            end
            s_wdrain: if (out_r == '0) begin
                state_n = s_read;
                idx_n = '0;
            end
            s_rdrain: if (out_r == '0) state_n = s_done;
            default: ;
        endcase
        if (to_evt) state_n = s_done;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= s_idle;
            idx_r <= '0;
            out_r <= '0;
            err_cnt_r <= '0;
            first_err_r <= '0;
        end else begin
            state_r <= state_n;
            idx_r <= idx_n;
            out_r <= out_n;
            if (err_inc & (err_cnt_r != 16'hFFFF)) err_cnt_r <= err_cnt_r + 16'd1;
            if (err_inc & (err_cnt_r == '0)) first_err_r <= err_addr;
        end
    end

`ifdef BP_MEM_TESTER_TIMEOUT_EN
    localparam int wd_width_lp = $clog2(timeout_p + 1);

    logic [wd_width_lp-1:0]   wd_r;
    logic [num_blocks_p-1:0]  pend_r;
    logic [idx_width_lp-1:0]  resp_idx, oldest_idx;
    logic [paddr_width_p-1:0] resp_off, oldest_addr;
    logic pending;

    assign pending  = issuing | (out_r != '0);
    assign to_evt   = checking & (wd_r == wd_width_lp'(timeout_p));
    assign resp_off = resp.addr - base_addr_p;
    assign resp_idx = idx_width_lp'(resp_off >> block_offset_lp);

    // Commands issue in index order, so the lowest pending index is the oldest
    always_comb begin
        oldest_idx = idx_r;
        for (int i = num_blocks_p - 1; i >= 0; i--) begin
            if (pend_r[i]) oldest_idx = idx_width_lp'(i);
        end
    end

    assign oldest_addr = base_addr_p + (paddr_width_p'(oldest_idx) << block_offset_lp);
    assign err_addr = err_evt ? resp.addr : oldest_addr;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wd_r <= '0;
            pend_r <= '0;
        end else begin
            if (~checking | cmd_fire | mem_resp_yumi_o) wd_r <= '0;
            else if (pending & ~to_evt) wd_r <= wd_r + wd_width_lp'(1);
            if (~checking) begin
                pend_r <= '0;
            end else begin
                if (cmd_fire) pend_r[idx_r] <= 1'b1;
                if (mem_resp_yumi_o & in_region) pend_r[resp_idx] <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_p;
    assign to_evt = 1'b0;
    assign err_addr = resp.addr;
`endif

    assign done_o = state_r == s_done;
    assign pass_o = done_o & (err_cnt_r == '0);
    assign error_count_o = err_cnt_r;
    assign first_err_addr_o = first_err_r;

endmodule

// File: tb/tb_bp_mem_tester.sv
// tb_bp_mem_tester: directed bench with a queued memory responder.
// Covers run/pass, stalls, corruption, outstanding limit, reset abort, timeout.
module tb_bp_mem_tester;
    import bp_mem_tester_pkg::*;

    localparam logic [paddr_width_p-1:0] BASE = 40'h00_8000_0000;
    localparam int NB = 8;
    localparam int MAXO = 4;
    localparam logic [63:0] SEED = 64'h0123_4567_89ab_cdef;
    localparam int TO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, start, ready, resp_v, cmd_v, yumi, done, pass;
    logic [cce_mem_msg_width_lp-1:0] cmd, resp;
    logic [15:0] errc;
    logic [paddr_width_p-1:0] ferr;
    bp_cce_mem_msg_s cmd_s;
    assign cmd_s = bp_cce_mem_msg_s'(cmd);

    bp_mem_tester #(
        .base_addr_p(BASE), .num_blocks_p(NB), .max_outstanding_p(MAXO),
        .seed_p(SEED), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start),
        .mem_cmd_o(cmd), .mem_cmd_v_o(cmd_v), .mem_cmd_ready_i(ready),
        .mem_resp_i(resp), .mem_resp_v_i(resp_v), .mem_resp_yumi_o(yumi),
        .done_o(done), .pass_o(pass), .error_count_o(errc),
        .first_err_addr_o(ferr)
    );

    int npass = 0, nfail = 0, ntotal = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [cce_block_width_p-1:0] pat(input logic [paddr_width_p-1:0] a);
        logic [cce_block_width_p-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*64 +: 64] = (64'(a) + 64'(8 * k)) ^ SEED;
        return d;
    endfunction

    typedef struct {
        bp_cce_mem_msg_s msg;
        int due;
    } pend_t;

    pend_t rq[$];
    bp_cce_mem_msg_s log_q[$];
    logic [cce_block_width_p-1:0] mem [logic [paddr_width_p-1:0]];
    int cyc = 0, lat = 1, tb_out = 0, peak = 0, stall_v = 0, over_max = 0;
    int last_hs = 0, done_cyc = 0;
    logic corrupt_en = 1'b0, drop_en = 1'b0;
    logic [paddr_width_p-1:0] corrupt_addr = '0, drop_addr = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : responder
        bp_cce_mem_msg_s c, r;
        logic chs, yhs;
        resp_v = 1'b0;
        resp = '0;
        forever begin
            @(negedge clk);
            chs = cmd_v & ready;
            yhs = yumi;
            c = cmd_s;
            if (!ready && cmd_v) stall_v++;
            if (chs && tb_out >= MAXO) over_max++;
            tick();
            cyc++;
            if (!reset_i) begin
                rq.delete();
                tb_out = 0;
            end else begin
                if (yhs) begin
                    void'(rq.pop_front());
                    tb_out--;
                    last_hs = cyc;
                end
                if (chs) begin
                    log_q.push_back(c);
                    tb_out++;
                    last_hs = cyc;
                    if (tb_out > peak) peak = tb_out;
                    r = '0;
                    r.addr = c.addr;
                    r.size = c.size;
                    r.payload = c.payload;
                    if (c.msg_type == e_cce_mem_wr) begin
                        mem[c.addr] = c.data;
                        r.msg_type = e_cce_mem_wr;
                    end else begin
                        r.msg_type = e_cce_mem_rd;
                        r.data = mem.exists(c.addr) ? mem[c.addr] : '0;
                        if (corrupt_en && c.addr == corrupt_addr) r.data[0] = ~r.data[0];
                    end
                    if (!(drop_en && c.msg_type == e_cce_mem_rd && c.addr == drop_addr))
                        rq.push_back('{r, cyc + lat - 1});
                end
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                resp_v = 1'b1;
                resp = rq[0].msg;
            end else begin
                resp_v = 1'b0;
                resp = '0;
            end
        end
    end

    task automatic do_reset();
        reset_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b1;
        tick();
        log_q.delete();
        peak = 0;
        stall_v = 0;
        over_max = 0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        chk(tag, done, 1);
    endtask

    task automatic check_log(input string tag);
        logic [paddr_width_p-1:0] a;
        logic [cce_block_width_p-1:0] e;
        chk({tag, "_count"}, log_q.size(), 2 * NB);
        for (int i = 0; i < log_q.size() && i < 2 * NB; i++) begin
            a = BASE + paddr_width_p'((i % NB) * 64);
            e = (i < NB) ? pat(a) : '0;
            chk({tag, "_addr"}, log_q[i].addr, a);
            chk({tag, "_type"}, log_q[i].msg_type, (i < NB) ? e_cce_mem_wr : e_cce_mem_rd);
            chk({tag, "_size"}, log_q[i].size, e_mem_size_64);
            chk({tag, "_payload"}, log_q[i].payload, 0);
            for (int k = 0; k < 8; k++)
                chk({tag, "_data"}, log_q[i].data[k*64 +: 64], e[k*64 +: 64]);
        end
    endtask

    initial begin : timeout_guard
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench stalled");
    end

    initial begin
        reset_i = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_cmd_v", cmd_v, 0);
        chk("rst_cmd", cmd_s.addr, 0);
        chk("rst_yumi", yumi, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_errc", errc, 0);
        chk("rst_ferr", ferr, 0);
        reset_i = 1'b1;
        tick();

        // Run A: first command the cycle after start, then a clean pass
        start = 1'b1;
        @(negedge clk);
        chk("A_v_before", cmd_v, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("A_first_v", cmd_v, 1);
        chk("A_first_addr", cmd_s.addr, BASE);
        chk("A_w0_word0", cmd_s.data[63:0], 64'h0123_4567_09ab_cdef);
        chk("A_w0_word1", cmd_s.data[127:64], 64'h0123_4567_09ab_cde7);
        wait_done(400, "A_done");
        chk("A_pass", pass, 1);
        chk("A_errc", errc, 0);
        chk("A_ferr", ferr, 0);
        check_log("A");

        // DONE is sticky and ignores start
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("A_sticky_done", done, 1);
        chk("A_sticky_v", cmd_v, 0);
        chk("A_sticky_log", log_q.size(), 2 * NB);

        // Run B: ready held low for 20 cycles mid-WRITE
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 50 && log_q.size() < 3; n++) tick();
        ready = 1'b0;
        repeat (20) tick();
        ready = 1'b1;
        wait_done(400, "B_done");
        chk("B_stall_v", stall_v, 0);
        chk("B_pass", pass, 1);
        check_log("B");

        // Run C: block 3 read data corrupted
        do_reset();
        corrupt_en = 1'b1;
        corrupt_addr = BASE + 40'h0C0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(400, "C_done");
        chk("C_errc", errc, 1);
        chk("C_ferr", ferr, 40'h00_8000_00C0);
        chk("C_pass", pass, 0);
        corrupt_en = 1'b0;

        // Run D: slow responder, outstanding limit
        do_reset();
        lat = 10;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1000, "D_done");
        chk("D_peak", peak, MAXO);
        chk("D_over_max", over_max, 0);
        chk("D_pass", pass, 1);
        chk("D_errc", errc, 0);
        lat = 1;

        // Run E: reset during READ, then a fresh run
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 200 && log_q.size() <= NB; n++) tick();
        chk("E_read_seen", log_q.size() > NB, 1);
        #2 reset_i = 1'b0;
        #1;
        chk("E_abort_v", cmd_v, 0);
        chk("E_abort_cmd", cmd_s.addr, 0);
        chk("E_abort_yumi", yumi, 0);
        chk("E_abort_done", done, 0);
        chk("E_abort_errc", errc, 0);
        repeat (2) tick();
        reset_i = 1'b1;
        tick();
        log_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(400, "E_done");
        chk("E_pass", pass, 1);
        chk("E_errc", errc, 0);
        check_log("E");

`ifdef BP_MEM_TESTER_TIMEOUT_EN
        // Run F: read of block 0 never answered
        do_reset();
        drop_en = 1'b1;
        drop_addr = BASE;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(600, "F_done");
        chk("F_errc", errc, 1);
        chk("F_ferr", ferr, BASE);
        chk("F_pass", pass, 0);
        chk("F_latency", (done_cyc - last_hs >= 95) && (done_cyc - last_hs <= 110), 1);
        drop_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/bp_mem_tester.md
Name: bp_mem_tester

Overview:
- Memory-side initiator/checker that drives the cce_mem command channel into a memory responder (bp_mem and friends) and consumes its response channel.
- Writes an address-derived pattern to a block region, reads every block back and compares.
- Used by bp_me unit benches to qualify memory models and the mem-to-DRAM path without a CCE present.

Parameters:
- bp_params_p, e_bp_default_cfg, proc config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p.
- base_addr_p, 0x8000_0000, block-aligned start address of the test region.
- num_blocks_p, 64, number of blocks tested; must be ≥1.
- max_outstanding_p, 4, maximum in-flight commands; must be ≥1.
- seed_p, 0, 64-bit XOR seed for the data pattern.
- timeout_p, 4096, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a test run; honoured only in IDLE.
- mem_cmd_o  out  cce_mem_msg_width_lp  command message.
- mem_cmd_v_o  out  1  command valid; ready->valid, asserted only while mem_cmd_ready_i=1.
- mem_cmd_ready_i  in  1  responder ready.
- mem_resp_i  in  cce_mem_msg_width_lp  response message.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed; equals mem_resp_v_i in WRITE/READ/DRAIN states.
- done_o  out  1  held high in DONE.
- pass_o  out  1  valid when done_o=1; high iff error_count_o==0.
- error_count_o  out  16  saturating mismatch count.
- first_err_addr_o  out  paddr_width_p  address of the first mismatching read.

Behaviour:
- While reset_i=0, all outputs are 0 and the state is IDLE. Assertion mid-run aborts immediately; in-flight responses are not tracked after reset.
- Block address for index i = base_addr_p + i*(cce_block_width_p/8).
- Pattern: 64-bit word k of the block at address A = zero_ext(A + 8k) XOR seed_p.
- Commands carry:
  - msg_type: block write (WRITE) or block read (READ).
  - size: full block.
  - addr: block address.
  - payload: lce_id 0, way 0.
  - data: the pattern for writes, zero for reads.
- Outstanding counter:
  - Increments on each command handshake (mem_cmd_v_o & mem_cmd_ready_i) and decrements on each mem_resp_yumi_o.
  - Simultaneous increment and decrement leaves it unchanged.
  - No command is issued while outstanding == max_outstanding_p.
- FSM:
  - IDLE -> WRITE on start_i.
  - WRITE: issue writes for i=0..num_blocks_p-1. When the last write is issued, -> WDRAIN.
  - WDRAIN: wait for outstanding==0, then reset the index -> READ.
  - READ: issue reads for i=0..num_blocks_p-1. When the last read is issued, -> RDRAIN.
  - RDRAIN: wait for outstanding==0 -> DONE.
  - DONE: sticky until reset. start_i is ignored.
- Response checking:
  - Write responses: msg_type must be write; anything else is an error.
  - Read responses: data is compared against the pattern recomputed from mem_resp_i addr, so the check is order-independent.
  - A mismatch, or an address outside the region, increments error_count_o, saturating at 0xFFFF.
  - first_err_addr_o is captured only on the first error.
- Latency: the first command is presented the cycle after start_i, provided ready is high. Throughput is one command per cycle.
- Both index counters are wide enough for num_blocks_p with no wrap-around; the index stops at num_blocks_p-1.

Optional Feature:
- Macro: BP_MEM_TESTER_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on any command or response handshake and on IDLE/DONE.
  - It counts while outstanding>0 or a command is pending.
  - When it reaches timeout_p, the FSM moves to DONE, error_count_o increments once, and first_err_addr_o is set to the address of the oldest pending command if no error was captured earlier.
- Without the macro: no watchdog logic; a hung responder leaves the FSM stalled.

Decomposition:
- bp_me_pkg additions:
  - bp_mem_tester_state_e enum: IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
  - Pattern word-width constant: 64.
- Reuse the cce_mem message struct via declare_bp_mem_if.
- One sub-module: bp_mem_tester_pattern. Combinational: address + seed -> block pattern. Instanced twice, once for write data and once for the read check.

Test Plan:
- Fixed-latency bp_mem, num_blocks_p=8, max_outstanding_p=1, start_i pulse -> 8 writes then 8 reads; done_o high; pass_o=1; error_count_o=0.
- Hold mem_cmd_ready_i low for 20 cycles mid-WRITE -> no mem_cmd_v_o during the stall; no duplicate or skipped addresses.
- Responder corrupts the read data of block 3 (addr base+0xC0 for 512-bit blocks) -> error_count_o=1; first_err_addr_o=base+0xC0; pass_o=0.
- max_outstanding_p=4 with a responder delaying responses 10 cycles -> outstanding peaks at 4; never 5; all 64 blocks pass.
- Pulse reset_i low during READ, then start again -> outputs clear immediately; the second run passes.
- With BP_MEM_TESTER_TIMEOUT_EN, timeout_p=100, responder drops the read of block 0 -> done_o at ~100 cycles after the last handshake; error_count_o=1; first_err_addr_o=base.
